pipelined_adder: RTL and testbench
==================================

Name: pipelined_adder

Overview:
- Parametrised, pipelined ripple-chunk adder/subtractor for the ALU datapath. Next generation of the fixed 32-bit ripple adder.
- Splits a WIDTH-bit add into STAGES = WIDTH/CHUNK registered chunks. The inter-chunk carry travels between pipeline registers.
- Adds subtract mode, valid/ready handshake with backpressure, and carry/overflow/zero flags.
- Sits between the operand-select stage and the ALU result mux. Throughput is one operation per cycle.

Parameters:
- WIDTH, 32, operand/result width in bits. Must be a multiple of CHUNK.
- CHUNK, 16, bits added per pipeline stage. Must be ≥1 and ≤ WIDTH.

Ports:
- clk_in  input  1  clock, all state rising-edge.
- rst_n_in  input  1  asynchronous active-low reset.
- valid_in  input  1  operands/controls valid this cycle.
- ready_out  output  1  block can accept an operation this cycle.
- operand1_in  input  WIDTH  operand A.
- operand2_in  input  WIDTH  operand B.
- carry_in  input  1  carry into bit 0. For subtract, 1 means no borrow.
- sub_in  input  1  0: A+B+carry_in; 1: A+~B+carry_in.
- valid_out  output  1  result_out/flags valid.
- ready_in  input  1  downstream accepts result this cycle.
- result_out  output  WIDTH  sum/difference.
- carry_out  output  1  carry out of bit WIDTH-1. For subtract, 0 means borrow occurred.
- overflow_out  output  1  signed (two's-complement) overflow.
- zero_out  output  1  result_out == 0.

Behaviour:
- Reset (async assert, sync deassert edge irrelevant to spec): all stage valid bits, valid_out, result_out, carry_out, overflow_out, zero_out = 0. ready_out = 1 while out of reset.
- Advance = ~valid_out | ready_in. ready_out = advance, which is combinational from ready_in and valid_out.
- Transfer in: valid_in & ready_out on a rising edge. Transfer out: valid_out & ready_in.
- When advance = 0, every pipeline register holds, including valid bits, data, skew registers and flags. Outputs stay stable until accepted.
- When advance = 1, all stages shift one step. Stage 0 captures valid_in, so bubbles propagate as valid = 0.
- Stage k (k = 0..STAGES-1):
  - Adds chunk k of A and B_eff with the carry from stage k-1 (stage 0 uses carry_in). B_eff = sub_in ? ~B : B, inverted at input.
  - Registers the chunk sum, the chunk carry, and the not-yet-added upper operand chunks (skew).
  - Forwards the already-computed lower result chunks.
- Latency: STAGES cycles from input transfer to valid_out (2 at defaults). With ready_in held high, back-to-back inputs produce back-to-back outputs.
- STAGES = 1 degenerates to a single registered adder with latency 1.
- Flags are computed in the final stage from the registered result:
  - carry_out = final chunk carry.
  - overflow_out = (A[W-1] == B_eff[W-1]) & (result[W-1] != A[W-1]).
  - zero_out = ~|result.
- Flags are registered with result_out and change only with it.
- A data register holding valid = 0 is don't-care for result/flags. A bench must only check outputs when valid_out = 1.
- Reset mid-operation: all in-flight operations are discarded and valid_out drops to 0 immediately. No partial result is ever presented.
- Simultaneous in/out transfer at full occupancy is legal and loses nothing.
- Elaboration error if WIDTH % CHUNK != 0.

Test Plan:
- Defaults: add A=0xFFFFFFFF, B=0x00000001, carry_in=0, ready_in=1 -> two cycles later valid_out=1, result=0x00000000, carry=1, zero=1, overflow=0. Exercises the inter-stage carry.
- Subtract A=5, B=7, carry_in=1, sub=1 -> result=0xFFFFFFFE, carry=0, overflow=0, zero=0.
- Add A=0x7FFFFFFF, B=1, carry_in=0 -> result=0x80000000, overflow=1, carry=0. Subtract A=0x80000000, B=1, carry_in=1 -> result=0x7FFFFFFF, overflow=1, carry=1.
- Stream of 8 ops (A=i, B=i, i=1..8) with ready_in=1 -> 8 consecutive valid outputs 2,4,...,16 starting on cycle 2.
- Backpressure: same stream with ready_in=0 for cycles 3-5 -> ready_out=0 while valid_out=1. Outputs held stable. No op lost or duplicated; order preserved.
- Assert rst_n_in for one cycle while 2 ops are in flight -> valid_out=0 immediately and flags cleared. Only ops issued after release appear.
- WIDTH=8, CHUNK=2 (STAGES=4): 0xFF+0x01 -> result 0x00, carry=1, latency 4.

Source files
------------

// File: rtl/pipelined_adder_if.sv
// pipelined_adder_if: operand/result handshake bundle for pipelined_adder
//   master: drives operands, controls, valid_in and ready_in
//   slave : drives ready_out, valid_out, result_out and the carry/overflow/zero flags
interface pipelined_adder_if #(parameter int WIDTH = 32);
  logic             valid_in;
  logic             ready_out;
  logic [WIDTH-1:0] operand1_in;
  logic [WIDTH-1:0] operand2_in;
  logic             carry_in;
  logic             sub_in;
  logic             valid_out;
  logic             ready_in;
  logic [WIDTH-1:0] result_out;
  logic             carry_out;
  logic             overflow_out;
  logic             zero_out;
  modport master (
    output valid_in, operand1_in, operand2_in, carry_in, sub_in, ready_in,
    input  ready_out, valid_out, result_out, carry_out, overflow_out, zero_out
  );
  modport slave (
    input  valid_in, operand1_in, operand2_in, carry_in, sub_in, ready_in,
    output ready_out, valid_out, result_out, carry_out, overflow_out, zero_out
  );
endinterface

// File: rtl/pipelined_adder.sv
// pipelined_adder: WIDTH-bit add/subtract split into WIDTH/CHUNK registered ripple chunks
//   clk_in   : clock, all state rising-edge
//   rst_n_in : asynchronous active-low reset
//   bus      : slave side of pipelined_adder_if (operands, sub/carry controls,
//              valid/ready in both directions, result and carry/overflow/zero flags)
module pipelined_adder #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 16
) (
  input logic              clk_in,
  input logic              rst_n_in,
  pipelined_adder_if.slave bus
);
  localparam int STAGES = WIDTH / CHUNK;
  localparam int L = STAGES - 1;
  logic w_adv;
  logic r_ovf, r_zero;
  if (CHUNK < 1 || CHUNK > WIDTH || WIDTH % CHUNK != 0) begin : g_bad
    $error("pipelined_adder: WIDTH must be a positive multiple of CHUNK");
  end
  // The whole pipeline moves in lockstep; it only stalls when a finished result is unclaimed.
  assign w_adv = ~bus.valid_out | bus.ready_in;
  assign bus.ready_out = w_adv;
  for (genvar k = 0; k < STAGES; k++) begin : g_st
    localparam int HI = WIDTH - k * CHUNK;
    localparam int SW = (k + 1) * CHUNK;
    // w_a/w_b hold the operand bits not yet added, with this stage's chunk at the bottom.
    logic [HI-1:0]  w_a, w_b;
    logic           w_ci, w_v;
    logic [CHUNK:0] w_add;
    logic [SW-1:0]  w_sum;
    logic           r_v, r_c;
    logic [SW-1:0]  r_s;
    if (k == 0) begin : g_in
      assign w_a   = bus.operand1_in;
      assign w_b   = bus.sub_in ? ~bus.operand2_in : bus.operand2_in;
      assign w_ci  = bus.carry_in;
      assign w_v   = bus.valid_in;
      assign w_sum = w_add[CHUNK-1:0];
    end else begin : g_mid
      assign w_a   = g_st[k-1].g_skew.r_a;
      assign w_b   = g_st[k-1].g_skew.r_b;
      assign w_ci  = g_st[k-1].r_c;
      assign w_v   = g_st[k-1].r_v;
      assign w_sum = {w_add[CHUNK-1:0], g_st[k-1].r_s};
    end
    assign w_add = {1'b0, w_a[CHUNK-1:0]} + {1'b0, w_b[CHUNK-1:0]} + {{CHUNK{1'b0}}, w_ci};
    always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
        r_v <= 1'b0;
        r_c <= 1'b0;
        r_s <= '0;
      end else if (w_adv) begin
        r_v <= w_v;
        r_c <= w_add[CHUNK];
        r_s <= w_sum;
      end
    end
    // Only stages with work left downstream carry the upper operand chunks forward.
    if (k < L) begin : g_skew
      logic [HI-CHUNK-1:0] r_a, r_b;
      always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
          r_a <= '0;
          r_b <= '0;
        end else if (w_adv) begin
          r_a <= w_a[HI-1:CHUNK];
          r_b <= w_b[HI-1:CHUNK];
        end
      end
    end
  end
  // Flags are evaluated from the last stage's operand top bits and final sum, then registered with it.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_ovf  <= 1'b0;
      r_zero <= 1'b0;
    end else if (w_adv) begin
      r_ovf  <= (g_st[L].w_a[CHUNK-1] == g_st[L].w_b[CHUNK-1]) &
                (g_st[L].w_add[CHUNK-1] != g_st[L].w_a[CHUNK-1]);
      r_zero <= ~|g_st[L].w_sum;
    end
  end
  assign bus.valid_out    = g_st[L].r_v;
  assign bus.result_out   = g_st[L].r_s;
  assign bus.carry_out    = g_st[L].r_c;
  assign bus.overflow_out = r_ovf;
  assign bus.zero_out     = r_zero;
endmodule

// File: tb/tb_pipelined_adder.sv
// tb_pipelined_adder: directed self-checking bench for pipelined_adder (32/16 and 8/2 configurations)
module tb_pipelined_adder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_tests = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  pipelined_adder_if #(.WIDTH(32)) bus ();
  pipelined_adder_if #(.WIDTH(8))  bus8 ();
  pipelined_adder #(.WIDTH(32), .CHUNK(16)) u_dut (.clk_in(clk), .rst_n_in(rst_n), .bus(bus.slave));
  pipelined_adder #(.WIDTH(8),  .CHUNK(2))  u_dut8 (.clk_in(clk), .rst_n_in(rst_n), .bus(bus8.slave));
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic run32(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic ci, input logic sub, input logic [31:0] er,
                       input logic ec, input logic eo, input logic ez);
    int lat;
    bus.operand1_in = a;
    bus.operand2_in = b;
    bus.carry_in = ci;
    bus.sub_in = sub;
    bus.valid_in = 1'b1;
    bus.ready_in = 1'b1;
    @(negedge clk);
    bus.valid_in = 1'b0;
    lat = 1;
    while (!bus.valid_out && lat < 12) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_lat"}, lat, 2);
    check({tag, "_res"}, bus.result_out, er);
    check({tag, "_c"}, bus.carry_out, ec);
    check({tag, "_ovf"}, bus.overflow_out, eo);
    check({tag, "_z"}, bus.zero_out, ez);
    @(negedge clk);
  endtask
  task automatic run8(input string tag, input logic [7:0] a, input logic [7:0] b,
                      input logic ci, input logic sub, input logic [7:0] er,
                      input logic ec, input logic eo, input logic ez);
    int lat;
    bus8.operand1_in = a;
    bus8.operand2_in = b;
    bus8.carry_in = ci;
    bus8.sub_in = sub;
    bus8.valid_in = 1'b1;
    bus8.ready_in = 1'b1;
    @(negedge clk);
    bus8.valid_in = 1'b0;
    lat = 1;
    while (!bus8.valid_out && lat < 12) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_lat"}, lat, 4);
    check({tag, "_res"}, bus8.result_out, er);
    check({tag, "_c"}, bus8.carry_out, ec);
    check({tag, "_ovf"}, bus8.overflow_out, eo);
    check({tag, "_z"}, bus8.zero_out, ez);
    @(negedge clk);
  endtask
  task automatic stream(input string tag, input logic bp);
    logic [31:0] got[$];
    logic [31:0] held = '0;
    logic stalled = 1'b0;
    int first = -1;
    int last = -1;
    int idx = 0;
    bus.carry_in = 1'b0;
    bus.sub_in = 1'b0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      bus.ready_in = !(bp && cyc >= 3 && cyc <= 5);
      bus.valid_in = idx < 8;
      bus.operand1_in = 32'(idx + 1);
      bus.operand2_in = 32'(idx + 1);
      #1;
      if (stalled && bus.valid_out) check({tag, "_hold"}, bus.result_out, held);
      stalled = 1'b0;
      if (bus.valid_out && !bus.ready_in) begin
        check({tag, "_rdy"}, bus.ready_out, 0);
        stalled = 1'b1;
        held = bus.result_out;
      end
      if (bus.valid_out && bus.ready_in) begin
        if (first < 0) first = cyc;
        last = cyc;
        got.push_back(bus.result_out);
      end
      if (bus.valid_in && bus.ready_out) idx++;
      @(negedge clk);
    end
    bus.valid_in = 1'b0;
    bus.ready_in = 1'b1;
    check({tag, "_cnt"}, got.size(), 8);
    check({tag, "_first"}, first, 2);
    check({tag, "_last"}, last, bp ? 12 : 9);
    for (int j = 0; j < 8; j++)
      check({tag, "_val"}, j < got.size() ? got[j] : 32'hDEAD_BEEF, 2 * (j + 1));
  endtask
  initial begin
    #100000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end
  initial begin
    int seen;
    bus.valid_in = 1'b0;
    bus.operand1_in = '0;
    bus.operand2_in = '0;
    bus.carry_in = 1'b0;
    bus.sub_in = 1'b0;
    bus.ready_in = 1'b0;
    bus8.valid_in = 1'b0;
    bus8.operand1_in = '0;
    bus8.operand2_in = '0;
    bus8.carry_in = 1'b0;
    bus8.sub_in = 1'b0;
    bus8.ready_in = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("rst_vld", bus.valid_out, 0);
    check("rst_res", bus.result_out, 0);
    check("rst_c", bus.carry_out, 0);
    check("rst_ovf", bus.overflow_out, 0);
    check("rst_z", bus.zero_out, 0);
    check("rst_rdy", bus.ready_out, 1);
    check("rst_vld8", bus8.valid_out, 0);
    rst_n = 1'b1;
    @(negedge clk);
    run32("wrap", 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
    run32("sub57", 32'd5, 32'd7, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
    run32("povf", 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
    run32("novf", 32'h8000_0000, 32'h1, 1'b1, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);
    run32("midc", 32'h0000_FFFF, 32'h1, 1'b0, 1'b0, 32'h0001_0000, 1'b0, 1'b0, 1'b0);
    run32("subeq", 32'h1234_5678, 32'h1234_5678, 1'b1, 1'b1, 32'h0, 1'b1, 1'b0, 1'b1);
    stream("strm", 1'b0);
    stream("bp", 1'b1);
    bus.ready_in = 1'b0;
    bus.operand1_in = 32'hFFFF_FFFF;
    bus.operand2_in = 32'h1;
    bus.carry_in = 1'b0;
    bus.sub_in = 1'b0;
    bus.valid_in = 1'b1;
    @(negedge clk);
    bus.operand1_in = 32'd200;
    bus.operand2_in = 32'd2;
    @(negedge clk);
    bus.valid_in = 1'b0;
    check("mid_pre_vld", bus.valid_out, 1);
    check("mid_pre_z", bus.zero_out, 1);
    rst_n = 1'b0;
    #1;
    check("mid_vld", bus.valid_out, 0);
    check("mid_res", bus.result_out, 0);
    check("mid_c", bus.carry_out, 0);
    check("mid_z", bus.zero_out, 0);
    check("mid_ovf", bus.overflow_out, 0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.ready_in = 1'b1;
    seen = 0;
    repeat (5) begin
      @(negedge clk);
      if (bus.valid_out) seen++;
    end
    check("mid_ghost", seen, 0);
    run32("post_rst", 32'd3, 32'd4, 1'b0, 1'b0, 32'd7, 1'b0, 1'b0, 1'b0);
    run8("w8_wrap", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
    run8("w8_povf", 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0);
    run8("w8_sub", 8'h10, 8'h20, 1'b1, 1'b1, 8'hF0, 1'b0, 1'b0, 1'b0);
    run8("w8_cin", 8'h55, 8'h2A, 1'b1, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
